// File: rtl/pong_game_sequencer.sv
// Game-phase sequencer for the VGA pong design: turns frame ticks, gamepad
// buttons and ball events into move/reload strobes, score and ball speed.
module pong_game_sequencer #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SPEEDUP_HITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               hit_paddle,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               move_strobe,
  output logic               ball_load,
  output logic               serve_dir,
  output logic [2:0]         ball_speed,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               winner
);

  localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FC_W = $clog2(FMAX + 1);
  localparam int HC_W = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_POINT     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t            st_q;
  logic              start_prev, pause_prev;
  logic [FC_W-1:0]   frame_cnt;
  logic [HC_W-1:0]   hit_cnt;

  wire start_edge = start_btn & ~start_prev;
  wire pause_edge = pause_btn & ~pause_prev;

  wire [FC_W-1:0] frame_nxt   = frame_cnt + 1'b1;
  wire            serve_done  = frame_tick && (frame_nxt == FC_W'(SERVE_FRAMES));
  wire            point_done  = frame_tick && (frame_nxt == FC_W'(POINT_FRAMES));
  wire            hit_wrap    = (hit_cnt == HC_W'(SPEEDUP_HITS - 1));
  wire            l_won       = (score_l == SCORE_W'(WIN_SCORE));
  wire            r_won       = (score_r == SCORE_W'(WIN_SCORE));

  assign state = st_q;

  // Button history; resets high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
    end
  end

  // Game FSM with registered strobes, scoreboard and speed control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= S_IDLE;
      move_strobe <= 1'b0;
      ball_load   <= 1'b0;
      serve_dir   <= 1'b1;
      ball_speed  <= 3'd1;
      score_l     <= '0;
      score_r     <= '0;
      winner      <= 1'b0;
      frame_cnt   <= '0;
      hit_cnt     <= '0;
    end else begin
      move_strobe <= 1'b0;
      ball_load   <= 1'b0;
      case (st_q)
        S_IDLE: begin
          score_l    <= '0;
          score_r    <= '0;
          ball_speed <= 3'd1;
          hit_cnt    <= '0;
          serve_dir  <= 1'b1;
          if (start_edge) begin
            st_q      <= S_SERVE;
            ball_load <= 1'b1;
            frame_cnt <= '0;
          end
        end
        S_SERVE: begin
          if (serve_done) begin
            st_q      <= S_PLAY;
            frame_cnt <= '0;
          end else if (frame_tick) begin
            frame_cnt <= frame_nxt;
          end
        end
        S_PLAY: begin
          if (miss_left) begin
            if (!r_won) score_r <= score_r + 1'b1;
            serve_dir <= 1'b0;
            st_q      <= S_POINT;
            frame_cnt <= '0;
          end else if (miss_right) begin
            if (!l_won) score_l <= score_l + 1'b1;
            serve_dir <= 1'b1;
            st_q      <= S_POINT;
            frame_cnt <= '0;
          end else if (pause_edge) begin
            st_q      <= S_PAUSED;
            frame_cnt <= '0;
          end else begin
            move_strobe <= frame_tick;
            if (hit_paddle) begin
              if (hit_wrap) begin
                hit_cnt <= '0;
                if (ball_speed != 3'd7) ball_speed <= ball_speed + 3'd1;
              end else begin
                hit_cnt <= hit_cnt + 1'b1;
              end
            end
          end
        end
        S_PAUSED: begin
          if (pause_edge) begin
            st_q      <= S_PLAY;
            frame_cnt <= '0;
          end
        end
        S_POINT: begin
          if (point_done) begin
            frame_cnt <= '0;
            if (l_won || r_won) begin
              st_q   <= S_GAME_OVER;
              winner <= r_won;
            end else begin
              st_q       <= S_SERVE;
              ball_load  <= 1'b1;
              ball_speed <= 3'd1;
              hit_cnt    <= '0;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_nxt;
          end
        end
        S_GAME_OVER: begin
          if (start_edge) begin
            score_l    <= '0;
            score_r    <= '0;
            ball_speed <= 3'd1;
            hit_cnt    <= '0;
            serve_dir  <= 1'b1;
            ball_load  <= 1'b1;
            frame_cnt  <= '0;
            st_q       <= S_SERVE;
          end
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
